// File: rtl/exception_wb_stage.sv
// Carries execute-stage exception codes through X/M and M/W, redirects the writeback to $rstatus,
// and tracks a sticky pending/overrun status with ack. Optional commit counter: define EXC_COUNT_EN.
module exception_wb_stage #(
  parameter logic [4:0] RSTATUS_ADDR = 5'd30,
  parameter int         CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_x,
  input  logic [2:0]       exc_x,
  input  logic             wb_we_in,
  input  logic [4:0]       wb_addr_in,
  input  logic [31:0]      wb_data_in,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             exc_pending,
  output logic [2:0]       exc_code,
  output logic             exc_overrun,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  logic [2:0] xm_exc;
  logic [2:0] mw_exc;
  logic       commit;
  state_t     state;

  // Flush wins over stall for X/M only; M/W simply holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      xm_exc <= 3'd0;
      mw_exc <= 3'd0;
    end else begin
      if (flush)       xm_exc <= 3'd0;
      else if (!stall) xm_exc <= valid_x ? exc_x : 3'd0;
      if (!stall)      mw_exc <= xm_exc;
    end
  end

  // Override stays asserted during stall; rewriting r30 with the same code is harmless.
  always_comb begin
    wb_we   = wb_we_in;
    wb_addr = wb_addr_in;
    wb_data = wb_data_in;
    if (mw_exc != 3'd0) begin
      wb_we   = 1'b1;
      wb_addr = RSTATUS_ADDR;
      wb_data = {29'b0, mw_exc};
    end
  end

  assign commit = (mw_exc != 3'd0) && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      exc_code    <= 3'd0;
      exc_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (commit) begin
            state    <= PEND;
            exc_code <= mw_exc;
          end
        end
        PEND: begin
          if (commit) begin
            exc_code    <= mw_exc;
            exc_overrun <= !exc_ack;
          end else if (exc_ack) begin
            state       <= IDLE;
            exc_overrun <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign exc_pending = (state == PEND);

`ifdef EXC_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)                     cnt <= '0;
    else if (commit && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

  assign exc_count = cnt;
`else
  assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exception_wb_stage.sv
// Scoreboard bench for exception_wb_stage: codes queued at issue, popped when an r30 commit appears.
module tb_exception_wb_stage;

  localparam int CNT_W = 4;
`ifdef EXC_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, stall, flush, valid_x, wb_we_in, exc_ack;
  logic [2:0]       exc_x;
  logic [4:0]       wb_addr_in;
  logic [31:0]      wb_data_in;
  logic             wb_we, exc_pending, exc_overrun;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic [2:0]       exc_code;
  logic [CNT_W-1:0] exc_count;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  exception_wb_stage #(.RSTATUS_ADDR(5'd30), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_x(valid_x), .exc_x(exc_x),
    .wb_we_in(wb_we_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_pending(exc_pending), .exc_code(exc_code), .exc_overrun(exc_overrun),
    .exc_ack(exc_ack), .exc_count(exc_count)
  );

  always #5 clock = ~clock;

  // A committing r30 write must match the oldest issued code.
  always @(negedge clock) begin
    if (!reset && !stall && wb_we && wb_addr == 5'd30) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: got data=%0h, no code expected", wb_data);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (wb_data !== {29'b0, e}) begin
          failures++;
          $display("FAIL commit_data: got %0h expected %0h", wb_data, {29'b0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic issue(input logic [2:0] code);
    valid_x = 1'b1;
    exc_x   = code;
    if (!flush && code != 3'd0) exp_q.push_back(code);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_x = 1'b0; exc_x = 3'd0; exc_ack = 1'b0;
    wb_we_in = 1'b1; wb_addr_in = 5'd5; wb_data_in = 32'hDEADBEEF;
    tick(); tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== 5'b0 || exc_count !== '0) begin
      failures++;
      $display("FAIL reset_status: got p=%b c=%0d o=%b n=%0d expected all 0",
               exc_pending, exc_code, exc_overrun, exc_count);
    end
    wb_we_in = 1'b0; wb_addr_in = 5'd9; wb_data_in = 32'h1234_5678;
    #1;
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd9, 32'h1234_5678}) begin
      failures++;
      $display("FAIL reset_passthru: got we=%b a=%0d d=%h expected 0/9/12345678", wb_we, wb_addr, wb_data);
    end
  endtask

  task automatic test_add_overflow();
    do_reset();
    issue(3'd1);
    tick();                      // cycle 1
    valid_x = 1'b0;
    checks++;
    if (wb_addr !== 5'd5) begin
      failures++;
      $display("FAIL add_early_override: got addr=%0d expected 5", wb_addr);
    end
    tick();                      // cycle 2
    exc_ack = 1'b1;              // ack in IDLE must not block the commit
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd30, 32'd1} || exc_pending !== 1'b0) begin
      failures++;
      $display("FAIL add_override: got we=%b a=%0d d=%0h p=%b expected 1/30/1/0", wb_we, wb_addr, wb_data, exc_pending);
    end
    tick();                      // cycle 3
    exc_ack = 1'b0;
    checks++;
    if (exc_pending !== 1'b1 || exc_code !== 3'd1 || exc_count !== (CNT_ON ? 4'd1 : 4'd0)) begin
      failures++;
      $display("FAIL add_status: got p=%b c=%0d n=%0d expected 1/1/%0d", exc_pending, exc_code, exc_count, CNT_ON);
    end
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    checks++;
    if (exc_pending !== 1'b0 || exc_code !== 3'd1 || exc_count !== (CNT_ON ? 4'd1 : 4'd0)) begin
      failures++;
      $display("FAIL add_ack: got p=%b c=%0d n=%0d expected 0/1/%0d", exc_pending, exc_code, exc_count, CNT_ON);
    end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1;
    issue(3'd3);
    tick();
    valid_x = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL flush_passthru: got we=%b a=%0d d=%h expected 1/5/deadbeef", wb_we, wb_addr, wb_data);
    end
    tick();
    checks++;
    if (exc_pending !== 1'b0) begin
      failures++;
      $display("FAIL flush_pending: got %b expected 0", exc_pending);
    end
    // Flush during stall must still squash the code held in X/M.
    issue(3'd3);
    exp_q.delete();
    tick();
    valid_x = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_addr !== 5'd5 || exc_pending !== 1'b0) begin
        failures++;
        $display("FAIL flush_stall[%0d]: got a=%0d p=%b expected 5/0", i, wb_addr, exc_pending);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    issue(3'd2);
    tick();
    valid_x = 1'b0;
    tick();                      // cycle 2: code in M/W
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall = 1'b0;
      #1;
      checks++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd30, 32'd2} || exc_pending !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got we=%b a=%0d d=%0h p=%b expected 1/30/2/0", i, wb_we, wb_addr, wb_data, exc_pending);
      end
      tick();
    end
    checks++;
    if (exc_pending !== 1'b1 || exc_code !== 3'd2 || exc_count !== (CNT_ON ? 4'd1 : 4'd0) || wb_addr !== 5'd5) begin
      failures++;
      $display("FAIL stall_commit: got p=%b c=%0d n=%0d a=%0d expected 1/2/%0d/5", exc_pending, exc_code, exc_count, wb_addr, CNT_ON);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    issue(3'd1); tick();
    issue(3'd3); tick();
    valid_x = 1'b0; tick();      // cycle 3
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== {1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL overrun_first: got p=%b c=%0d o=%b expected 1/1/0", exc_pending, exc_code, exc_overrun);
    end
    tick();
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== {1'b1, 3'd3, 1'b1}) begin
      failures++;
      $display("FAIL overrun_second: got p=%b c=%0d o=%b expected 1/3/1", exc_pending, exc_code, exc_overrun);
    end
    exc_ack = 1'b1; tick(); exc_ack = 1'b0;
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== {1'b0, 3'd3, 1'b0}) begin
      failures++;
      $display("FAIL overrun_ack: got p=%b c=%0d o=%b expected 0/3/0", exc_pending, exc_code, exc_overrun);
    end
  endtask

  task automatic test_ack_commit();
    do_reset();
    issue(3'd1); tick();
    valid_x = 1'b0; tick(); tick();  // cycle 3, pending
    issue(3'd2); tick();
    valid_x = 1'b0; tick();          // cycle 5: code 2 commits this cycle
    exc_ack = 1'b1; tick(); exc_ack = 1'b0;
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== {1'b1, 3'd2, 1'b0} || exc_count !== (CNT_ON ? 4'd2 : 4'd0)) begin
      failures++;
      $display("FAIL ack_commit: got p=%b c=%0d o=%b n=%0d expected 1/2/0/%0d", exc_pending, exc_code, exc_overrun, exc_count, 2*CNT_ON);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq[6] = '{3'd7, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(seq[i]); tick();
    end
    valid_x = 1'b0; tick(); tick();
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== {1'b1, 3'd1, 1'b1} || exc_count !== (CNT_ON ? 4'd5 : 4'd0)) begin
      failures++;
      $display("FAIL back_to_back: got p=%b c=%0d o=%b n=%0d expected 1/1/1/%0d", exc_pending, exc_code, exc_overrun, exc_count, 5*CNT_ON);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(3'((i % 7) + 1)); tick();
    end
    valid_x = 1'b0; tick(); tick();
    checks++;
    if (exc_count !== (CNT_ON ? 4'd15 : 4'd0) || exc_code !== 3'd3 || exc_pending !== 1'b1) begin
      failures++;
      $display("FAIL saturation: got n=%0d c=%0d p=%b expected %0d/3/1", exc_count, exc_code, exc_pending, 15*CNT_ON);
    end
    // Reset with codes in flight: everything returns to reset values next cycle.
    issue(3'd1); tick();
    issue(3'd2); tick();
    reset = 1'b1; valid_x = 1'b0;
    exp_q.delete();
    tick();
    checks++;
    if ({exc_pending, exc_code, exc_overrun} !== 5'b0 || exc_count !== '0 || {wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL midstream_reset: got p=%b c=%0d o=%b n=%0d a=%0d expected 0/0/0/0/5",
               exc_pending, exc_code, exc_overrun, exc_count, wb_addr);
    end
    reset = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (exc_pending !== 1'b0 || wb_addr !== 5'd5) begin
      failures++;
      $display("FAIL reset_dropped: got p=%b a=%0d expected 0/5", exc_pending, wb_addr);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_flush();
    test_stall();
    test_overrun();
    test_ack_commit();
    test_back_to_back();
    test_saturation_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d codes never committed expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_wb_stage.md
# exception_wb_stage

Downstream consumer of the execute-stage exception code (0 none, 1 add overflow, 2 addi overflow, 3 sub overflow; 4–7 reserved). Carries the code through the X/M and M/W pipeline registers alongside the instruction that raised it. At writeback it overrides the register-file write so the code lands in $rstatus (r30). It also raises a sticky pending flag with an ack handshake for the interrupt/status logic.

## Interface
- RSTATUS_ADDR, 5'd30, register-file index of $rstatus
- CNT_W, 16, width of the exception counter (used only with EXC_COUNT_EN)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  holds both pipeline registers and suppresses commit
- flush  in  1  squashes the instruction entering X/M
- valid_x  in  1  instruction in X is valid
- exc_x  in  3  exception code from execute stage
- wb_we_in  in  1  normal writeback enable from W
- wb_addr_in  in  5  normal writeback address
- wb_data_in  in  32  normal writeback data
- wb_we  out  1  merged writeback enable to register file
- wb_addr  out  5  merged writeback address
- wb_data  out  32  merged writeback data
- exc_pending  out  1  sticky: an exception has committed and is not yet acked
- exc_code  out  3  code of most recent committed exception
- exc_overrun  out  1  a second exception committed while pending
- exc_ack  in  1  clears pending/overrun
- exc_count  out  CNT_W  committed-exception count

## Operation
- Registers: xm_exc[2:0], mw_exc[2:0]; reset both to 0.
- stall=0: xm_exc <= flush ? 0 : (valid_x ? exc_x : 0); mw_exc <= xm_exc.
- stall=1: mw_exc holds. xm_exc holds unless flush=1, which clears it (flush has priority over stall for xm_exc only).
- Writeback merge (combinational):
  - mw_exc != 0: wb_we=1, wb_addr=RSTATUS_ADDR, wb_data={29'b0, mw_exc}.
  - Otherwise pass wb_*_in through unchanged.
  - The override applies even while stalled; repeating the write is idempotent.
- Commit = (mw_exc != 0) & ~stall. Exactly one commit per excepting instruction.
- Status state machine (IDLE: pending=0; PEND: pending=1):
  - IDLE + commit -> PEND, exc_code <= mw_exc.
  - PEND + exc_ack, no commit -> IDLE; overrun <= 0; exc_code retained.
  - PEND + commit, no ack -> PEND, exc_code <= mw_exc, overrun <= 1.
  - PEND + commit + ack -> PEND, exc_code <= mw_exc, overrun <= 0.
  - exc_ack in IDLE is ignored.
- Codes 4–7 are treated as exceptions like 1–3: pipelined, written, committed.
- Reset mid-operation: all registers return to reset values on the next edge, and any in-flight code is dropped.

## Timing
- Reset values: xm_exc=0, mw_exc=0, exc_pending=0, exc_code=0, exc_overrun=0, exc_count=0. wb_* outputs equal wb_*_in.
- With no stalls, exc_x sampled at the edge ending cycle N:
  - xm_exc valid in cycle N+1.
  - mw_exc and the r30 override valid in cycle N+2.
  - exc_pending/exc_code valid from cycle N+3.
- Each stall cycle adds one cycle to this latency per affected stage.
- exc_ack is sampled at the edge; pending drops in the following cycle.

## Configuration
- EXC_COUNT_EN defined:
  - exc_count increments by 1 on each commit.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Unaffected by exc_ack; cleared only by reset.
- EXC_COUNT_EN undefined: no counter register; exc_count tied to 0.

## Test plan
- Reset, then add overflow: valid_x=1, exc_x=1 at cycle 0 -> wb_addr=30, wb_data=1, wb_we=1 in cycle 2; exc_pending=1, exc_code=1 in cycle 3; exc_count=1 (EXC_COUNT_EN).
- Flush: exc_x=3 with flush=1 -> no override, wb_* equal wb_*_in (e.g. addr 5, data 0xDEADBEEF), pending stays 0.
- Stall: exc_x=2, then stall=1 for 3 cycles while the code is in M/W -> r30 override held for all 4 cycles, exactly one commit, exc_count=1.
- Overrun: commit code 1, no ack, then commit code 3 -> exc_code=3, exc_overrun=1. exc_ack -> pending=0, overrun=0.
- Simultaneous ack+commit while pending -> pending stays 1, exc_code=new code, overrun=0.
- Saturation (EXC_COUNT_EN, CNT_W=4): 17 commits -> exc_count=15. Reset mid-stream -> all outputs return to reset values the next cycle.
